// File: rtl/scfifo_mc.sv
// scfifo_mc - multi-channel single-clock FIFO.
//
// NUM_CH independent logical FIFOs share one memory of NUM_CH*2**LOG_DEPTH
// words, addressed {channel, pointer}. Each channel keeps its own write
// pointer, read pointer and occupancy count. Status flags are decoded from
// the registered counts.
//
// Ports:
//   clk          : single clock, all state on the rising edge
//   aclr_n       : asynchronous active-low reset
//   wrreq/wrch   : write request and target channel, data = write word
//   rdreq/rdch   : read request and source channel
//   q/rdvalid    : registered read word, valid for one cycle after a read
//   empty/full/almost_empty/almost_full : per-channel status vectors
//   usedw        : word count of channel rdch (combinational)
//   overflow/underflow : sticky error flags
//
// Optional feature macro: SCFIFO_MC_CHECK_EN
//   defined   : writes to a full channel and reads from an empty channel are
//               rejected and set sticky overflow/underflow.
//   undefined : every request is accepted; overflow/underflow tied to 0.
module scfifo_mc #(
  parameter int NUM_CH             = 4,
  parameter int LOG_DEPTH          = 5,
  parameter int WIDTH              = 20,
  parameter int ALMOST_FULL_VALUE  = 30,
  parameter int ALMOST_EMPTY_VALUE = 2,
  localparam int CH_W              = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 wrreq,
  input  logic [CH_W-1:0]      wrch,
  input  logic [WIDTH-1:0]     data,
  input  logic                 rdreq,
  input  logic [CH_W-1:0]      rdch,
  output logic [WIDTH-1:0]     q,
  output logic                 rdvalid,
  output logic [NUM_CH-1:0]    empty,
  output logic [NUM_CH-1:0]    full,
  output logic [NUM_CH-1:0]    almost_empty,
  output logic [NUM_CH-1:0]    almost_full,
  output logic [LOG_DEPTH:0]   usedw,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH  = 1 << LOG_DEPTH;
  localparam int ADDR_W = CH_W + LOG_DEPTH;

  localparam logic [LOG_DEPTH:0]   CNT_ONE   = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH:0]   CNT_DEPTH = (LOG_DEPTH+1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_AF    = (LOG_DEPTH+1)'(ALMOST_FULL_VALUE);
  localparam logic [LOG_DEPTH:0]   CNT_AE    = (LOG_DEPTH+1)'(ALMOST_EMPTY_VALUE);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE   = LOG_DEPTH'(1);

  logic [WIDTH-1:0]     mem [NUM_CH*DEPTH];

  logic [LOG_DEPTH-1:0] wrptr_vec [NUM_CH];
  logic [LOG_DEPTH-1:0] rdptr_vec [NUM_CH];
  logic [LOG_DEPTH:0]   count_vec [NUM_CH];

  logic                 wr_ok, rd_ok;
  logic                 wr_acc, rd_acc;
  logic [ADDR_W-1:0]    wr_addr, rd_addr;

  logic [WIDTH-1:0]     q_q;
  logic                 rdvalid_q, rdvalid_d;

  // Requests to a channel index beyond NUM_CH are ignored outright.
  assign wr_ok = wrreq && (32'(wrch) < NUM_CH);
  assign rd_ok = rdreq && (32'(rdch) < NUM_CH);

`ifdef SCFIFO_MC_CHECK_EN
  // Emptiness is judged on the registered count, so a same-cycle write to
  // an empty channel does not make a read of it legal.
  assign wr_acc = wr_ok && !full[wrch];
  assign rd_acc = rd_ok && !empty[rdch];
`else
  assign wr_acc = wr_ok;
  assign rd_acc = rd_ok;
`endif

  assign wr_addr = {wrch, wrptr_vec[wrch]};
  assign rd_addr = {rdch, rdptr_vec[rdch]};

  // Per-channel pointer/count state and status decode.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [LOG_DEPTH-1:0] wrptr_q, wrptr_d;
    logic [LOG_DEPTH-1:0] rdptr_q, rdptr_d;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic                 wr_hit, rd_hit;

    always_comb begin
      wr_hit  = wr_acc && (32'(wrch) == gi);
      rd_hit  = rd_acc && (32'(rdch) == gi);
      wrptr_d = wr_hit ? wrptr_q + PTR_ONE : wrptr_q;
      rdptr_d = rd_hit ? rdptr_q + PTR_ONE : rdptr_q;
      count_d = count_q;
      if (wr_hit && !rd_hit) begin
        count_d = count_q + CNT_ONE;
      end else if (rd_hit && !wr_hit) begin
        count_d = count_q - CNT_ONE;
      end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
        wrptr_q <= '0;
        rdptr_q <= '0;
        count_q <= '0;
      end else begin
        wrptr_q <= wrptr_d;
        rdptr_q <= rdptr_d;
        count_q <= count_d;
      end
    end

    assign wrptr_vec[gi]    = wrptr_q;
    assign rdptr_vec[gi]    = rdptr_q;
    assign count_vec[gi]    = count_q;
    assign empty[gi]        = (count_q == '0);
    assign full[gi]         = (count_q == CNT_DEPTH);
    assign almost_full[gi]  = (count_q >= CNT_AF);
    assign almost_empty[gi] = (count_q <  CNT_AE);
  end

  // Shared storage: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_addr] <= data;
    end
  end

  assign rdvalid_d = rd_acc;

  // Registered read port; q holds its last value between reads.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      q_q       <= '0;
      rdvalid_q <= 1'b0;
    end else begin
      rdvalid_q <= rdvalid_d;
      if (rd_acc) begin
        q_q <= mem[rd_addr];
      end
    end
  end

  assign q       = q_q;
  assign rdvalid = rdvalid_q;
  assign usedw   = rd_ok ? count_vec[rdch] : ((32'(rdch) < NUM_CH) ? count_vec[rdch] : '0);

`ifdef SCFIFO_MC_CHECK_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr_ok && !wr_acc);
    underflow_d = underflow_q | (rd_ok && !rd_acc);
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_scfifo_mc.sv
// tb_scfifo_mc - self-checking bench for scfifo_mc (default parameters).
// A queue-per-channel model predicts every output; each cycle the outputs
// are compared on the falling edge. A few literal expectations pin the model.
module tb_scfifo_mc;

  localparam int NUM_CH = 4;
  localparam int LOG_DEPTH = 5;
  localparam int WIDTH = 20;
  localparam int DEPTH = 32;
  localparam int AF = 30;
  localparam int AE = 2;

  logic              clk;
  logic              aclr_n;
  logic              wrreq;
  logic [1:0]        wrch;
  logic [WIDTH-1:0]  data;
  logic              rdreq;
  logic [1:0]        rdch;
  logic [WIDTH-1:0]  q;
  logic              rdvalid;
  logic [3:0]        empty, full, almost_empty, almost_full;
  logic [LOG_DEPTH:0] usedw;
  logic              overflow, underflow;

  scfifo_mc #(
    .NUM_CH(NUM_CH), .LOG_DEPTH(LOG_DEPTH), .WIDTH(WIDTH),
    .ALMOST_FULL_VALUE(AF), .ALMOST_EMPTY_VALUE(AE)
  ) dut (
    .clk(clk), .aclr_n(aclr_n),
    .wrreq(wrreq), .wrch(wrch), .data(data),
    .rdreq(rdreq), .rdch(rdch),
    .q(q), .rdvalid(rdvalid),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .usedw(usedw), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model
  logic [WIDTH-1:0] mq [NUM_CH][$];
  logic [WIDTH-1:0] exp_q;
  logic             exp_rdv;
  logic             exp_ovf, exp_unf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    exp_q = '0; exp_rdv = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  // Compare every output against the model.
  task automatic check_all();
    logic [3:0] e_empty, e_full, e_ae, e_af;
    for (int c = 0; c < NUM_CH; c++) begin
      e_empty[c] = (mq[c].size() == 0);
      e_full[c]  = (mq[c].size() == DEPTH);
      e_ae[c]    = (mq[c].size() < AE);
      e_af[c]    = (mq[c].size() >= AF);
    end
    chk("empty", 32'(empty), 32'(e_empty));
    chk("full", 32'(full), 32'(e_full));
    chk("almost_empty", 32'(almost_empty), 32'(e_ae));
    chk("almost_full", 32'(almost_full), 32'(e_af));
    chk("usedw", 32'(usedw), 32'(mq[rdch].size()));
    chk("rdvalid", 32'(rdvalid), 32'(exp_rdv));
    chk("q", 32'(q), 32'(exp_q));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
  endtask

  // One clock: drive, update model at the edge, compare on the falling edge.
  task automatic cycle(input bit w, input int wc, input logic [WIDTH-1:0] d,
                       input bit r, input int rc);
    wrreq = w; wrch = 2'(wc); data = d; rdreq = r; rdch = 2'(rc);
    @(posedge clk);
    exp_rdv = 1'b0;
    if (r) begin
      if (mq[rc].size() > 0) begin
        exp_q   = mq[rc].pop_front();
        exp_rdv = 1'b1;
      end else begin
        exp_unf = 1'b1;
      end
    end
    if (w) begin
      if (mq[wc].size() < DEPTH) mq[wc].push_back(d);
      else exp_ovf = 1'b1;
    end
    @(negedge clk);
    $display("cyc wr=%0d ch%0d d=0x%0h rd=%0d ch%0d -> q=0x%0h rdvalid=%0d usedw=%0d",
             w, wc, d, r, rc, q, rdvalid, usedw);
    check_all();
    wrreq = 1'b0; rdreq = 1'b0;
  endtask

  initial begin
    aclr_n = 1'b0; wrreq = 1'b0; wrch = '0; data = '0; rdreq = 1'b0; rdch = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    chk("reset_empty_lit", 32'(empty), 32'hF);
    chk("reset_ae_lit", 32'(almost_empty), 32'hF);
    aclr_n = 1'b1;

    // Two words through ch1.
    cycle(1, 1, 20'hA, 0, 1);
    cycle(1, 1, 20'hB, 0, 1);
    cycle(0, 0, 0, 1, 1);
    chk("q_first_lit", 32'(q), 32'hA);
    chk("rdvalid_first_lit", 32'(rdvalid), 32'h1);
    cycle(0, 0, 0, 1, 1);
    chk("q_second_lit", 32'(q), 32'hB);
    cycle(0, 0, 0, 0, 1);
    chk("rdvalid_drop_lit", 32'(rdvalid), 32'h0);
    chk("empty1_lit", 32'(empty[1]), 32'h1);

    // Fill ch0 completely.
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1, 0, 20'(i * 7 + 3), 0, 0);
      if (i == AF - 1) chk("af_before_lit", 32'(almost_full[0]), 32'h0);
      if (i == AF)     chk("af_at_lit", 32'(almost_full[0]), 32'h1);
      if (i == DEPTH - 1) chk("full_before_lit", 32'(full[0]), 32'h0);
    end
    chk("full_lit", 32'(full[0]), 32'h1);
    chk("usedw_full_lit", 32'(usedw), 32'd32);

`ifdef SCFIFO_MC_CHECK_EN
    // Overflow on full ch0, underflow on empty ch3.
    cycle(1, 0, 20'hFFFFF, 0, 0);
    chk("overflow_lit", 32'(overflow), 32'h1);
    cycle(0, 0, 0, 1, 3);
    chk("underflow_lit", 32'(underflow), 32'h1);
    chk("rdvalid_unf_lit", 32'(rdvalid), 32'h0);
`endif
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1, 0);
    chk("drained_lit", 32'(empty[0]), 32'h1);

    // Move ch2's pointers close to the wrap point.
    cycle(1, 2, 20'h100, 0, 2);
    for (int i = 1; i < 28; i++) cycle(1, 2, 20'(20'h100 + i), 1, 2);
    cycle(0, 2, 0, 1, 2);
    for (int i = 0; i < 5; i++) cycle(1, 2, 20'(20'h200 + i), 0, 2);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 2, 20'(20'h300 + i), 1, 2);
      chk("usedw_steady_lit", 32'(usedw), 32'd5);
    end
    for (int i = 0; i < 5; i++) cycle(0, 2, 0, 1, 2);
    chk("q_wrap_lit", 32'(q), 32'h309);

    // Interleaved writes, reverse-order reads.
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < NUM_CH; c++) cycle(1, c, 20'((c << 8) | k), 0, 0);
    for (int c = NUM_CH - 1; c >= 0; c--)
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, c);
    chk("q_interleave_lit", 32'(q), 32'h002);

    // Reset mid-operation with a read in flight.
    for (int i = 0; i < 3; i++) cycle(1, 1, 20'(20'h500 + i), 0, 1);
    wrreq = 1'b0; rdreq = 1'b1; rdch = 2'd1;
    @(posedge clk);
    #2;
    rdreq = 1'b0;
    chk("inflight_rdvalid_lit", 32'(rdvalid), 32'h1);
    aclr_n = 1'b0;
    #1;
    chk("rst_rdvalid_lit", 32'(rdvalid), 32'h0);
    chk("rst_empty_lit", 32'(empty), 32'hF);
    chk("rst_usedw_lit", 32'(usedw), 32'h0);
    chk("rst_q_lit", 32'(q), 32'h0);
    model_reset();
    @(negedge clk);
    check_all();
    aclr_n = 1'b1;

    // Random legal traffic.
    for (int i = 0; i < 600; i++) begin
      bit w, r;
      int wc, rc;
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wc = $urandom_range(0, NUM_CH - 1);
      rc = $urandom_range(0, NUM_CH - 1);
      if (mq[wc].size() == DEPTH) w = 1'b0;
      if (mq[rc].size() == 0) r = 1'b0;
      cycle(w, wc, 20'($urandom), r, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
